// File: rtl/mcctrl_defs.sv
// Shared encodings for the multi-cycle RV32I-subset controller:
// states, opcodes, ALU/mux select codes and a memory-state helper.
package mcctrl_defs;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mcctrl_waitcnt.sv
// Memory wait-state counter with timeout compare. Runs only while a memory
// state is held without mem_ready, so every memory state starts from zero.
module mcctrl_waitcnt
  import mcctrl_defs::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic in_mem,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count;
  logic       waiting;

  assign waiting = in_mem && !mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (waiting) begin
      count <= count + 8'd1;
    end else begin
      count <= 8'd0;
    end
  end

  // A completing access on the limit cycle takes priority over the timeout.
  assign timeout = waiting && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller for a multi-cycle RV32I-subset datapath with a shared ALU
// and memory port. Optional perf counters are built when MCCTRL_PERF_EN is defined.
//
// state    | meaning
// IDLE     | post-reset, all outputs low
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | branch/jump target precomputed into ALUOut
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// MEM_ADDR | rs1 + imm address calculation
// MEM_RD   | load data read
// MEM_WR   | store data write
// WB_ALU   | write ALUOut to rd
// WB_MEM   | write MDR to rd
// BRANCH   | compare, PC <= target if zero
// JAL      | rd <= PC, PC <= target
// TRAP     | sticky fault, exit only via reset
module multicycle_ctrl
  import mcctrl_defs::*;
#(
  parameter int TIMEOUT = 255,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic [1:0]         mem_to_reg,
  output logic               trap,
  output logic [STATE_W-1:0] state_o
`ifdef MCCTRL_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
`endif
);

  state_e state;
  state_e next_state;
  logic   in_mem;
  logic   wait_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign in_mem  = is_mem_state(state);
  assign state_o = STATE_W'(state);

  mcctrl_waitcnt #(
    .TIMEOUT (TIMEOUT)
  ) u_waitcnt (
    .clk       (clk),
    .rst       (rst),
    .in_mem    (in_mem),
    .mem_ready (mem_ready),
    .timeout   (wait_timeout)
  );

  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = M2R_ALUOUT;
    trap          = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALUOP_ADD;
        pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (wait_timeout) begin
          next_state = S_TRAP;
        end
      end

      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALUOP_ADD;
        case (opcode)
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALUOP_FUNCT;
        next_state = S_WB_ALU;
      end

      S_EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_WB_ALU;
      end

      S_MEM_ADDR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALUOP_ADD;
        next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)         next_state = S_WB_MEM;
        else if (wait_timeout) next_state = S_TRAP;
      end

      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)         next_state = S_FETCH;
        else if (wait_timeout) next_state = S_TRAP;
      end

      S_WB_ALU: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_ALUOUT;
        next_state = S_FETCH;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        next_state    = S_FETCH;
      end

      // PC was already advanced in FETCH, so it is the link value here.
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_PC;
        pc_write   = 1'b1;
        pc_source  = PCSRC_ALUOUT;
        next_state = S_FETCH;
      end

      S_TRAP: trap = 1'b1;

      default: next_state = S_TRAP;
    endcase
  end

`ifdef MCCTRL_PERF_EN
  logic retire;

  assign retire = (next_state == S_FETCH) &&
                  ((state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_MEM_WR) ||
                   (state == S_BRANCH) || (state == S_JAL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if ((state != S_IDLE) && (state != S_TRAP)) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT=4); perf counter checks are
// compiled in when MCCTRL_PERF_EN is defined.
module tb_multicycle_ctrl;

  localparam logic [3:0] T_IDLE = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2, T_EXEC_R = 4'd3,
                         T_EXEC_I = 4'd4, T_MEM_ADDR = 4'd5, T_MEM_RD = 4'd6, T_MEM_WR = 4'd7,
                         T_WB_ALU = 4'd8, T_WB_MEM = 4'd9, T_BRANCH = 4'd10, T_JAL = 4'd11,
                         T_TRAP = 4'd12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg;
  logic       reg_write, trap;
  logic [3:0] state_o;
`ifdef MCCTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int total = 0;
  int bad = 0;

  multicycle_ctrl #(.TIMEOUT(4), .STATE_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .trap          (trap),
    .state_o       (state_o)
`ifdef MCCTRL_PERF_EN
    ,
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  wire [18:0] outs = {mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
                      pc_source, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, trap};

  function automatic logic [18:0] cv(input logic mreq, iod, mrd, mwr, irw, pcw, pcwc,
                                     input logic [1:0] pcs, asa, asb, aop,
                                     input logic rw, input logic [1:0] m2r, input logic trp);
    return {mreq, iod, mrd, mwr, irw, pcw, pcwc, pcs, asa, asb, aop, rw, m2r, trp};
  endfunction

  logic [18:0] v_zero, v_fetch1, v_fetch0, v_decode, v_exec_r, v_exec_i, v_mem_addr;
  logic [18:0] v_mem_rd, v_mem_wr, v_wb_alu, v_wb_mem, v_branch, v_jal, v_trap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] s, input logic [18:0] v);
    chk({tag, "_state"}, 32'(state_o), 32'(s));
    chk({tag, "_outs"}, 32'(outs), 32'(v));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b0;
    #1;
    st("rst_pulse", T_IDLE, v_zero);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    v_zero     = '0;
    v_fetch1   = cv(1,0,1,0,1,1,0, 2'b00,2'b00,2'b01,2'b00, 0,2'b00,0);
    v_fetch0   = cv(1,0,1,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 0,2'b00,0);
    v_decode   = cv(0,0,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 0,2'b00,0);
    v_exec_r   = cv(0,0,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b10, 0,2'b00,0);
    v_exec_i   = cv(0,0,0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10, 0,2'b00,0);
    v_mem_addr = cv(0,0,0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,2'b00,0);
    v_mem_rd   = cv(1,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,2'b00,0);
    v_mem_wr   = cv(1,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,2'b00,0);
    v_wb_alu   = cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,2'b00,0);
    v_wb_mem   = cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,2'b01,0);
    v_branch   = cv(0,0,0,0,0,0,1, 2'b01,2'b01,2'b00,2'b01, 0,2'b00,0);
    v_jal      = cv(0,0,0,0,0,1,0, 2'b01,2'b00,2'b00,2'b00, 1,2'b10,0);
    v_trap     = cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,2'b00,1);

    // Reset and one R-type with a zero-wait memory
    #1;
    st("reset", T_IDLE, v_zero);
    tick(); tick();
    st("reset_hold", T_IDLE, v_zero);
    rst = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
    tick(); st("r_fetch", T_FETCH, v_fetch1);
    tick(); st("r_decode", T_DECODE, v_decode);
    tick(); st("r_exec", T_EXEC_R, v_exec_r);
    tick(); st("r_wb", T_WB_ALU, v_wb_alu);
    tick(); st("r_next_fetch", T_FETCH, v_fetch1);

    // Load with three wait states in MEM_RD
    opcode = 7'b0000011;
    tick(); st("ld_decode", T_DECODE, v_decode);
    tick(); st("ld_addr", T_MEM_ADDR, v_mem_addr);
    mem_ready = 1'b0;
    tick(); st("ld_rd_w0", T_MEM_RD, v_mem_rd);
    tick(); st("ld_rd_w1", T_MEM_RD, v_mem_rd);
    tick(); st("ld_rd_w2", T_MEM_RD, v_mem_rd);
    tick(); mem_ready = 1'b1; #1;
    st("ld_rd_done", T_MEM_RD, v_mem_rd);
    tick(); st("ld_wb", T_WB_MEM, v_wb_mem);
    tick(); st("ld_next_fetch", T_FETCH, v_fetch1);

    // Branch
    opcode = 7'b1100011;
    tick(); st("br_decode", T_DECODE, v_decode);
    tick(); st("br_branch", T_BRANCH, v_branch);
    tick(); st("br_next_fetch", T_FETCH, v_fetch1);

    // I-type
    opcode = 7'b0010011;
    tick(); st("i_decode", T_DECODE, v_decode);
    tick(); st("i_exec", T_EXEC_I, v_exec_i);
    tick(); st("i_wb", T_WB_ALU, v_wb_alu);
    tick(); st("i_next_fetch", T_FETCH, v_fetch1);

    // JAL
    opcode = 7'b1101111;
    tick(); st("jal_decode", T_DECODE, v_decode);
    tick(); st("jal_jal", T_JAL, v_jal);
    tick(); st("jal_next_fetch", T_FETCH, v_fetch1);

    // Store, then asynchronous reset in the middle of MEM_WR
    opcode = 7'b0100011;
    tick(); st("st_decode", T_DECODE, v_decode);
    tick(); st("st_addr", T_MEM_ADDR, v_mem_addr);
    mem_ready = 1'b0;
    tick(); st("st_wr", T_MEM_WR, v_mem_wr);
    #3 rst = 1'b0;
    #1;
    chk("st_async_mem_write", 32'(mem_write), 32'd0);
    chk("st_async_state", 32'(state_o), 32'(T_IDLE));
    @(posedge clk);
    #1 rst = 1'b1; mem_ready = 1'b1;
    st("st_after_rst", T_IDLE, v_zero);
    tick(); st("st_restart_fetch", T_FETCH, v_fetch1);

    // Illegal opcode traps and stays trapped
    opcode = 7'b1111111;
    tick(); st("ill_decode", T_DECODE, v_decode);
    tick(); st("ill_trap", T_TRAP, v_trap);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tick();
      st("ill_trap_hold", T_TRAP, v_trap);
    end
    reset_pulse();
    opcode = 7'b0110011; mem_ready = 1'b0;

    // FETCH timeout at the limit with mem_ready low
    tick(); st("to_fetch_w0", T_FETCH, v_fetch0);
    for (int i = 1; i < 4; i++) begin
      tick(); st("to_fetch_wn", T_FETCH, v_fetch0);
    end
    tick(); st("to_fetch_limit", T_FETCH, v_fetch0);
    tick(); st("to_trap", T_TRAP, v_trap);
    reset_pulse();

    // mem_ready on the limit cycle completes the fetch
    tick(); st("lim_fetch_w0", T_FETCH, v_fetch0);
    for (int i = 1; i < 4; i++) begin
      tick(); st("lim_fetch_wn", T_FETCH, v_fetch0);
    end
    tick(); mem_ready = 1'b1; #1;
    st("lim_fetch_ready", T_FETCH, v_fetch1);
    tick(); st("lim_decode", T_DECODE, v_decode);
    tick(); st("lim_exec", T_EXEC_R, v_exec_r);

`ifdef MCCTRL_PERF_EN
    reset_pulse();
    mem_ready = 1'b1; opcode = 7'b0110011;
    repeat (13) tick();
    chk("perf_state", 32'(state_o), 32'(T_FETCH));
    chk("perf_cycle_cnt", cycle_cnt, 32'd12);
    chk("perf_instret_cnt", instret_cnt, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences a multi-cycle RV32I-subset datapath.
- Reuses one ALU and one unified memory port across instruction phases.
- Drives PC/IR write enables, mux selects, ALUOp and register-file write.
- Runs a valid/ready handshake with a memory that may insert wait states; traps on illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT, default 255: maximum wait cycles in a memory state before trapping; counter is 8 bits wide.
- STATE_W, default 4: width of the state register and the state_o port.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- ir_write  out  1  latch instruction into IR
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update gated by ALU zero
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = oldPC
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = 4, 10 = imm
- alu_op  out  2  to ALUCtrl: 00 = add, 01 = sub, 10 = funct-decoded
- reg_write  out  1  register-file write enable
- mem_to_reg  out  2  writeback select: 00 = ALUOut, 01 = MDR, 10 = PC
- trap  out  1  sticky fault flag
- state_o  out  STATE_W  current state, for debug

Behaviour:
- Reset: rst low forces state = IDLE immediately (asynchronously), clears the wait counter and trap. All outputs are 0 in IDLE. IDLE moves to FETCH on the first clk edge with rst high.
- Outputs are decoded purely from the current state; the exceptions are ir_write and pc_write in FETCH, which are also qualified by mem_ready.
- FETCH:
  - mem_req=1, mem_read=1, i_or_d=0.
  - alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=00.
  - On mem_ready: ir_write=1, pc_write=1, next state DECODE. Otherwise hold.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (precomputes the branch/jump target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> TRAP
- EXEC_R: a=01, b=00, op=10 -> WB_ALU.
- EXEC_I: a=01, b=10, op=10 -> WB_ALU.
- MEM_ADDR: a=01, b=10, op=00 -> MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, mem_read=1, i_or_d=1. On mem_ready -> WB_MEM.
- MEM_WR: mem_req=1, mem_write=1, i_or_d=1. On mem_ready -> FETCH.
- WB_ALU: reg_write=1, mem_to_reg=00 -> FETCH.
- WB_MEM: reg_write=1, mem_to_reg=01 -> FETCH.
- BRANCH: a=01, b=00, op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JAL: reg_write=1, mem_to_reg=10 (PC already holds PC+4), pc_write=1, pc_source=01 -> FETCH.
- Wait counter:
  - Cleared on entry to each memory state (FETCH, MEM_RD, MEM_WR).
  - Increments each cycle that state is held with mem_ready=0.
  - If the counter equals TIMEOUT while mem_ready=0, next state is TRAP.
  - mem_ready high in the same cycle as the limit wins: the access completes normally.
- TRAP: all strobes 0, trap=1. Exits only via reset.
- Zero-wait latency in cycles: R/I = 4, load = 5, store = 4, branch = 3, jal = 3. Each wait state adds 1.
- mem_req stays asserted and steady while waiting; no strobe glitches between a request and its mem_ready.
- Reset mid-access: rst low during MEM_WR drops mem_write in the same cycle (asynchronously).

Optional Feature:
- Macro: MCCTRL_PERF_EN.
- When defined:
  - Adds output ports cycle_cnt[31:0] and instret_cnt[31:0], both cleared by reset.
  - cycle_cnt increments every clk outside IDLE and TRAP.
  - instret_cnt increments on each transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH or JAL.
  - Both counters wrap at 2^32.
- When not defined: neither port exists and no counter logic is built.

Decomposition:
- Shared package/header mcctrl_defs: state encodings; opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL); ALUOp, ALU source and mem_to_reg select encodings.
- One natural sub-module, mcctrl_waitcnt: the wait counter plus its timeout compare.

Test Plan:
- Reset then R-type add (0110011), mem_ready always 1 -> states IDLE, FETCH, DECODE, EXEC_R, WB_ALU, FETCH; reg_write=1 for exactly 1 cycle; alu_op=10 in EXEC_R.
- Load (0000011) with mem_ready held low 3 cycles in MEM_RD -> mem_req high for 4 cycles, then WB_MEM with mem_to_reg=01; instruction takes 8 cycles total.
- Branch (1100011) -> BRANCH drives pc_write_cond=1, pc_source=01, alu_op=01 for 1 cycle; pc_write stays 0.
- Illegal opcode 1111111 -> TRAP after DECODE; trap=1 and all strobes 0 for 20 cycles; rst pulse low returns to IDLE with trap=0.
- TIMEOUT=4 with mem_ready held low in FETCH -> TRAP entered after 4 wait cycles; a second run with mem_ready=1 exactly on the limit cycle -> DECODE, no trap.
- rst driven low mid-cycle during MEM_WR -> mem_write falls before the next edge, state_o=IDLE. With MCCTRL_PERF_EN, after 3 zero-wait R-types -> instret_cnt=3, cycle_cnt=12.
